capture_ctrl_axil: RTL and testbench
====================================

// Module: capture_ctrl_axil
// PURPOSE
//  AXI4-Lite responder for the digitizer capture-control registers at 0x6000_0000 (PS GP master side).
//  Turns CTRL/PKT_SIZE writes into a start pulse and a packet length for the ADC capture packetizer.
//  Counts accepted stream beats, flags the last beat and reports BUSY/DONE/ERR/COUNT to software.
// PARAMETERS
//  ADDR_WIDTH        4         AXI address bits decoded (byte address; 4 word regs)
//  DEFAULT_PKT_SIZE  32'h1000  PKT_SIZE reset value, bytes
//  CNT_WIDTH         24        beat counter width; PKT_SIZE>>2 saturates at 2^CNT_WIDTH-1
// PORTS
//  clk             in   1           system clock (all logic)
//  resetn          in   1           synchronous, active-low reset
//  s_axi_awaddr    in   ADDR_WIDTH  write address
//  s_axi_awvalid   in   1           / s_axi_awready out 1
//  s_axi_wdata     in   32          write data
//  s_axi_wstrb     in   4           byte enables
//  s_axi_wvalid    in   1           / s_axi_wready out 1
//  s_axi_bresp     out  2           always 2'b00
//  s_axi_bvalid    out  1           / s_axi_bready in 1
//  s_axi_araddr    in   ADDR_WIDTH  read address
//  s_axi_arvalid   in   1           / s_axi_arready out 1
//  s_axi_rdata     out  32          read data
//  s_axi_rresp     out  2           always 2'b00
//  s_axi_rvalid    out  1           / s_axi_rready in 1
//  cap_start       out  1           1-cycle pulse: begin packet
//  cap_abort       out  1           1-cycle pulse: drop packet
//  cap_len         out  CNT_WIDTH   packet length in 32-bit words, latched at start
//  cap_beat        in   1           one accepted 32-bit stream word (tvalid&tready)
//  cap_last        out  1           busy && beat_cnt==cap_len-1 (drives tlast)
//  busy            out  1           packet in progress
// BEHAVIOUR
//  Reset: all ready/valid/pulse outputs 0, rdata 0, busy 0, cnt 0, DONE/ERR 0, PKT_SIZE=DEFAULT.
//  Write: AW and W accepted independently; awready=!aw_held&&!bvalid, likewise wready.
//   Register update in the cycle both are held; bvalid the next cycle, held until bready.
//   wstrb honoured per byte; unmapped addresses: write ignored, OKAY response.
//  Read: arready=!rvalid; rdata registered, rvalid 1 cycle after AR handshake, held until rready.
//   Read and write in the same cycle: read returns the pre-write value.
//  Map: 0x0 CTRL  W: b0 START, b1 ABORT (self-clearing, read 0).
//       0x4 STAT  R: b0 BUSY, b1 DONE, b2 ERR; W1C on b1,b2.
//       0x8 PKT_SIZE RW bytes; b[1:0] read 0.  0xC COUNT R: beats in current/last packet.
//  FSM IDLE->RUN on START when len=PKT_SIZE>>2 !=0: cap_start pulse, cap_len latched,
//   cnt=0, DONE=0, busy=1 the cycle after the write.
//  START with len==0: stays IDLE, ERR=1. START while RUN: ignored, ERR=1.
//  RUN: cnt++ per cap_beat; beat with cnt==len-1 -> IDLE, DONE=1, busy=0 next cycle, COUNT=len.
//  ABORT in RUN: cap_abort pulse, -> IDLE, DONE=0, COUNT keeps beats so far.
//   START+ABORT in the same write: abort wins. ABORT in IDLE: no effect.
//  PKT_SIZE writes during RUN update the register only; cap_len is unchanged.
//  cap_beat in IDLE: ignored. resetn low mid-transfer: all handshakes dropped next cycle.
// TESTING
//  Reset, read 0x0/0x4/0x8/0xC -> 0, 0, 0x1000, 0; all rresp/bresp 2'b00.
//  Write 0x8=0x40000, 0x0=1 -> one cap_start, cap_len=0x10000, BUSY=1;
//   65536 beats -> cap_last on beat 65535, STAT=0x2, COUNT=0x10000.
//  AW 3 cycles before W, then W before AW, with bready held low 5 cycles
//   -> each write performed once, bvalid held until bready.
//  PKT_SIZE=0, START -> no cap_start, STAT=0x4; write 0x4=0x4 -> STAT=0.
//  START, 10 beats, write 0x0=3 -> cap_abort pulse, BUSY=0, DONE=0, COUNT=10.
//  Write 0x8 wstrb=4'b0001 data 0xFFFF_FFFC on 0x1000 -> PKT_SIZE=0x10FC.

Source files
------------

// File: rtl/capture_ctrl_axil.sv
// AXI4-Lite register block for the ADC capture packetizer: decodes CTRL/STAT/PKT_SIZE/COUNT,
// issues start/abort pulses and tracks accepted stream beats against the latched packet length.
module capture_ctrl_axil #(
    parameter int          ADDR_WIDTH       = 4,
    parameter logic [31:0] DEFAULT_PKT_SIZE = 32'h1000,
    parameter int          CNT_WIDTH        = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  cap_start,
    output logic                  cap_abort,
    output logic [CNT_WIDTH-1:0]  cap_len,
    input  logic                  cap_beat,
    output logic                  cap_last,
    output logic                  busy
);

    // Handshake contract: a transfer completes on a rising edge where valid && ready;
    // valid is never withdrawn by this block before the matching ready, and ready
    // depends only on internal state, never combinationally on the master's valid.

    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] A_STAT  = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] A_PKT   = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] A_COUNT = ADDR_WIDTH'(4'hC);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic                   alive_q, alive_d;
    logic                   aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic                   w_held_q, w_held_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            pkt_size_q, pkt_size_d;
    logic [CNT_WIDTH-1:0]   cap_len_q, cap_len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   cap_start_q, cap_start_d;
    logic                   cap_abort_q, cap_abort_d;

    logic                   wr_en;
    logic                   start_req;
    logic                   abort_req;
    logic [29:0]            pkt_words;
    logic [CNT_WIDTH-1:0]   len_sat;
    logic [31:0]            rd_mux;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // Readies stay low while reset is asserted and for the first cycle after release.
    assign s_axi_awready = alive_q && !aw_held_q && !bvalid_q;
    assign s_axi_wready  = alive_q && !w_held_q && !bvalid_q;
    assign s_axi_arready = alive_q && !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign cap_start     = cap_start_q;
    assign cap_abort     = cap_abort_q;
    assign cap_len       = cap_len_q;
    assign busy          = (state_q == S_RUN);
    assign cap_last      = (state_q == S_RUN) && (cnt_q == cap_len_q - 1'b1);

    assign wr_en     = aw_held_q && w_held_q;
    assign start_req = wr_en && (awaddr_q == A_CTRL) && wstrb_q[0] && wdata_q[0];
    assign abort_req = wr_en && (awaddr_q == A_CTRL) && wstrb_q[0] && wdata_q[1];
    assign pkt_words = pkt_size_q[31:2];
    assign len_sat   = (pkt_words > 30'(CNT_MAX)) ? CNT_MAX : pkt_words[CNT_WIDTH-1:0];

    always_comb begin
        rd_mux = 32'h0;
        case (s_axi_araddr)
            A_STAT:  rd_mux = {29'h0, err_q, done_q, busy};
            A_PKT:   rd_mux = pkt_size_q;
            A_COUNT: rd_mux = 32'(cnt_q);
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        alive_d     = 1'b1;
        aw_held_d   = aw_held_q;
        awaddr_d    = awaddr_q;
        w_held_d    = w_held_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        pkt_size_d  = pkt_size_q;
        cap_len_d   = cap_len_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        err_d       = err_q;
        cap_start_d = 1'b0;
        cap_abort_d = 1'b0;

        if (s_axi_awvalid && s_axi_awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_en) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end

        if (wr_en && (awaddr_q == A_PKT)) begin
            pkt_size_d = apply_strb(pkt_size_q, wdata_q, wstrb_q) & 32'hFFFF_FFFC;
        end
        if (wr_en && (awaddr_q == A_STAT) && wstrb_q[0]) begin
            if (wdata_q[1]) done_d = 1'b0;
            if (wdata_q[2]) err_d  = 1'b0;
        end

        // Sampled registers give the pre-write value when a read and write coincide.
        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (s_axi_arvalid && s_axi_arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req && !abort_req) begin
                    if (len_sat != '0) begin
                        state_d     = S_RUN;
                        cap_start_d = 1'b1;
                        cap_len_d   = len_sat;
                        cnt_d       = '0;
                        done_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cap_beat) cnt_d = cnt_q + 1'b1;
                if (abort_req) begin
                    state_d     = S_IDLE;
                    cap_abort_d = 1'b1;
                    done_d      = 1'b0;
                end else begin
                    if (start_req) err_d = 1'b1;
                    if (cap_beat && (cnt_q == cap_len_q - 1'b1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            alive_q     <= 1'b0;
            aw_held_q   <= 1'b0;
            awaddr_q    <= '0;
            w_held_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            pkt_size_q  <= DEFAULT_PKT_SIZE;
            cap_len_q   <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_start_q <= 1'b0;
            cap_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alive_q     <= alive_d;
            aw_held_q   <= aw_held_d;
            awaddr_q    <= awaddr_d;
            w_held_q    <= w_held_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            pkt_size_q  <= pkt_size_d;
            cap_len_q   <= cap_len_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cap_start_q <= cap_start_d;
            cap_abort_q <= cap_abort_d;
        end
    end

endmodule

// File: tb/tb_capture_ctrl_axil.sv
// Bench for capture_ctrl_axil: register table, packet run with tlast tracking,
// split-channel writes, abort/error paths and mid-transfer reset.
module tb_capture_ctrl_axil;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        cap_start;
    logic        cap_abort;
    logic [23:0] cap_len;
    logic        cap_beat;
    logic        cap_last;
    logic        busy;

    always #5 clk = ~clk;

    capture_ctrl_axil dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .cap_start(cap_start),
        .cap_abort(cap_abort), .cap_len(cap_len), .cap_beat(cap_beat), .cap_last(cap_last),
        .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    int start_cnt = 0;
    int abort_cnt = 0;
    int last_err = 0;
    int last_seen = 0;

    always @(negedge clk) begin
        if (cap_start) start_cnt++;
        if (cap_abort) abort_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly = 0, input int w_dly = 0, input int b_dly = 0);
        bit aw_done = 0, w_done = 0, b_done = 0;
        bit hs_aw = 0, hs_w = 0, hs_b = 0, bv_seen = 0, bv_drop = 0;
        int c = 0;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!b_done && c < 100) begin
            @(negedge clk);
            if (hs_aw) begin s_axi_awvalid = 1'b0; aw_done = 1; hs_aw = 0; end
            if (hs_w)  begin s_axi_wvalid  = 1'b0; w_done  = 1; hs_w  = 0; end
            if (hs_b)  begin s_axi_bready  = 1'b0; b_done  = 1; end
            if (!b_done) begin
                if (!aw_done && c >= aw_dly) s_axi_awvalid = 1'b1;
                if (!w_done && c >= w_dly)   s_axi_wvalid  = 1'b1;
                s_axi_bready = (c >= b_dly);
                if (bv_seen && !s_axi_bvalid) bv_drop = 1;
                if (s_axi_bvalid) bv_seen = 1;
                hs_aw = s_axi_awvalid && s_axi_awready;
                hs_w  = s_axi_wvalid && s_axi_wready;
                hs_b  = s_axi_bvalid && s_axi_bready;
                if (hs_b) check("bresp", 32'(s_axi_bresp), 32'h0);
            end
            c++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        check("write_completed", 32'(b_done), 32'h1);
        check("bvalid_held", 32'(bv_drop), 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        bit ar_done = 0, r_done = 0, hs_ar = 0, hs_r = 0;
        logic [31:0] want;
        int c = 0;
        exp_q.push_back(exp);
        s_axi_araddr = addr;
        while (!r_done && c < 100) begin
            @(negedge clk);
            if (hs_ar) begin s_axi_arvalid = 1'b0; ar_done = 1; hs_ar = 0; end
            if (hs_r)  begin s_axi_rready  = 1'b0; r_done  = 1; end
            if (!r_done) begin
                s_axi_arvalid = !ar_done;
                s_axi_rready  = ar_done;
                hs_ar = s_axi_arvalid && s_axi_arready;
                hs_r  = s_axi_rvalid && s_axi_rready;
                if (hs_r) begin
                    want = exp_q.pop_front();
                    check(name, s_axi_rdata, want);
                    check("rresp", 32'(s_axi_rresp), 32'h0);
                end
            end
            c++;
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        if (!r_done && exp_q.size() > 0) void'(exp_q.pop_front());
        check("read_completed", 32'(r_done), 32'h1);
    endtask

    task automatic do_beats(input int n, input int first_idx, input int len);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_beat = 1'b1;
            if (cap_last !== ((first_idx + i) == len - 1)) last_err++;
            if (cap_last) last_seen++;
        end
        @(negedge clk);
        cap_beat = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    int s0, a0;

    initial begin
        vecs[0]  = '{0, 4'h0, 32'h0,         4'h0, 32'h0};
        vecs[1]  = '{0, 4'h4, 32'h0,         4'h0, 32'h0};
        vecs[2]  = '{0, 4'h8, 32'h0,         4'h0, 32'h0000_1000};
        vecs[3]  = '{0, 4'hC, 32'h0,         4'h0, 32'h0};
        vecs[4]  = '{1, 4'h8, 32'hFFFF_FFFC, 4'h1, 32'h0};
        vecs[5]  = '{0, 4'h8, 32'h0,         4'h0, 32'h0000_10FC};
        vecs[6]  = '{1, 4'h8, 32'hAABB_CCDF, 4'hC, 32'h0};
        vecs[7]  = '{0, 4'h8, 32'h0,         4'h0, 32'hAABB_10FC};
        vecs[8]  = '{1, 4'hC, 32'h0000_1234, 4'hF, 32'h0};
        vecs[9]  = '{0, 4'hC, 32'h0,         4'h0, 32'h0};
        vecs[10] = '{1, 4'h8, 32'h1234_567B, 4'hF, 32'h0};
        vecs[11] = '{0, 4'h8, 32'h0,         4'h0, 32'h1234_5678};

        resetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; cap_beat = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axi_awready), 32'h0);
        check("rst_wready", 32'(s_axi_wready), 32'h0);
        check("rst_arready", 32'(s_axi_arready), 32'h0);
        check("rst_valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_busy_pulses", {29'h0, busy, cap_start, cap_abort}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rdata", i));
        end

        // Full 64K-word packet with a PKT_SIZE rewrite part-way through.
        axi_write(4'h8, 32'h0004_0000, 4'hF);
        s0 = start_cnt;
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        check("long_start_pulses", 32'(start_cnt - s0), 32'h1);
        check("long_cap_len", 32'(cap_len), 32'h0001_0000);
        check("long_busy", 32'(busy), 32'h1);
        axi_read(4'h4, 32'h1, "long_stat_busy");
        last_err = 0; last_seen = 0;
        do_beats(100, 0, 65536);
        axi_write(4'h8, 32'h0000_0100, 4'hF);
        check("run_pkt_write_len", 32'(cap_len), 32'h0001_0000);
        do_beats(65436, 100, 65536);
        check("long_busy_done", 32'(busy), 32'h0);
        check("cap_last_pattern_errs", 32'(last_err), 32'h0);
        check("cap_last_count", 32'(last_seen), 32'h1);
        axi_read(4'h4, 32'h2, "long_stat_done");
        axi_read(4'hC, 32'h0001_0000, "long_count");
        axi_read(4'h8, 32'h0000_0100, "run_pkt_reg");
        axi_write(4'h4, 32'h2, 4'hF);
        axi_read(4'h4, 32'h0, "done_w1c");

        // Split channels with bready held off; each write must act exactly once.
        axi_write(4'h8, 32'h0000_0200, 4'hF, 0, 3, 10);
        axi_read(4'h8, 32'h0000_0200, "aw_first_pkt");
        s0 = start_cnt;
        axi_write(4'h0, 32'h1, 4'hF, 3, 0, 10);
        repeat (2) @(negedge clk);
        check("w_first_start_once", 32'(start_cnt - s0), 32'h1);
        check("w_first_cap_len", 32'(cap_len), 32'h80);
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        check("start_in_run_ignored", 32'(start_cnt - s0), 32'h1);
        axi_read(4'h4, 32'h5, "start_in_run_stat");
        do_beats(10, 0, 128);
        a0 = abort_cnt;
        axi_write(4'h0, 32'h3, 4'hF);
        repeat (2) @(negedge clk);
        check("abort_pulse", 32'(abort_cnt - a0), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_no_start", 32'(start_cnt - s0), 32'h1);
        axi_read(4'h4, 32'h4, "abort_stat");
        axi_read(4'hC, 32'd10, "abort_count");
        axi_write(4'h4, 32'h4, 4'hF);
        axi_read(4'h4, 32'h0, "err_w1c");
        axi_write(4'h0, 32'h2, 4'hF);
        repeat (2) @(negedge clk);
        check("abort_idle_no_pulse", 32'(abort_cnt - a0), 32'h1);

        // Zero-length start and beats while idle.
        axi_write(4'h8, 32'h0, 4'hF);
        s0 = start_cnt;
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        check("zero_len_no_start", 32'(start_cnt - s0), 32'h0);
        axi_read(4'h4, 32'h4, "zero_len_err");
        axi_write(4'h4, 32'h4, 4'hF);
        axi_read(4'h4, 32'h0, "zero_len_clear");
        do_beats(3, 1000, 0);
        axi_read(4'hC, 32'd10, "idle_beats_ignored");

        // Reset in the middle of a packet and an outstanding AW.
        axi_write(4'h8, 32'h40, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'h1);
        s_axi_awaddr = 4'h8; s_axi_awvalid = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_hs", {29'h0, s_axi_awready, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        s_axi_awvalid = 1'b0;
        resetn = 1'b1;
        axi_read(4'h8, 32'h0000_1000, "post_reset_pkt");
        axi_read(4'hC, 32'h0, "post_reset_count");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
